// File: rtl/frame_write_arbiter.sv
// frame_write_arbiter
//
// Arbitrates between two frame writers that share one image-buffer FIFO port.
// A writer raises its level request. The arbiter grants one writer at a time,
// alternating when both request. It then runs that writer through a four-phase
// handshake:
//   start -> start_ack -> stream packets -> done -> done_ack -> release.
// While streaming, the granted writer's packet interface is wired straight
// through to the FIFO with no register stage.
//
// Optional feature (macro FRAME_ARB_TIMEOUT_EN):
//   Adds a per-frame watchdog of TIMEOUT_CYCLES clocks. The watchdog aborts a
//   frame that stalls in START or STREAM. Without the macro there is no
//   watchdog and timeout_err is tied low.
//
// Ports
//   clock, reset              system clock; synchronous active-high reset
//   req0/1                    level request from writer n
//   start0/1, start_ack0/1    start handshake with writer n
//   done0/1, done_ack0/1      completion handshake with writer n
//   din0/1, din_valid0/1,     writer n packet {mask[3:0], frame, addr[16:0], data[31:0]}
//   din_ready0/1
//   dout, dout_valid,         packet stream to the image buffer FIFO
//   dout_ready
//   busy                      arbiter is not idle
//   grant                     current or most recently granted writer
//   frame_count               completed frames, free-running 16-bit wrap
//   timeout_err               one-cycle pulse when the watchdog aborts a frame

module frame_write_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  output logic        start0,
  output logic        start1,
  input  logic        start_ack0,
  input  logic        start_ack1,
  input  logic        done0,
  input  logic        done1,
  output logic        done_ack0,
  output logic        done_ack1,
  input  logic [53:0] din0,
  input  logic [53:0] din1,
  input  logic        din_valid0,
  input  logic        din_valid1,
  output logic        din_ready0,
  output logic        din_ready1,
  output logic [53:0] dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        busy,
  output logic        grant,
  output logic [15:0] frame_count,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StStream,
    StAck,
    StRelease
  } state_e;

  state_e      state_q, state_d;
  logic        grant_q, grant_d;
  logic [15:0] frame_count_q;

  // Handshake inputs of whichever writer currently holds the grant.
  logic sel_start_ack;
  logic sel_done;

  assign sel_start_ack = grant_q ? start_ack1 : start_ack0;
  assign sel_done      = grant_q ? done1      : done0;

  // High for one cycle when the watchdog aborts the frame in START or STREAM.
  logic wdog_expired;

`ifdef FRAME_ARB_TIMEOUT_EN
  localparam logic [31:0] WdogLast = 32'(TIMEOUT_CYCLES - 1);

  logic [31:0] wdog_q;
  logic        timeout_err_q;
  logic        wdog_active;

  assign wdog_active  = (state_q == StStart) || (state_q == StStream);
  assign wdog_expired = wdog_active && (wdog_q == WdogLast);

  // The count restarts on every START entry, so each frame gets the full budget.
  always_ff @(posedge clock) begin
    if (reset) begin
      wdog_q        <= 32'd0;
      timeout_err_q <= 1'b0;
    end else begin
      timeout_err_q <= wdog_expired;
      if ((state_d == StStart) && (state_q != StStart)) begin
        wdog_q <= 32'd0;
      end else if (wdog_active) begin
        wdog_q <= wdog_q + 32'd1;
      end
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign wdog_expired = 1'b0;
  // TIMEOUT_CYCLES has no effect in this build; the term is always false.
  assign timeout_err  = 1'b0 && (TIMEOUT_CYCLES != 32'd0);
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      grant_q       <= 1'b1;  // writer 0 wins the first contested round
      frame_count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      if (state_q == StAck) begin
        frame_count_q <= frame_count_q + 16'd1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          // On contention the writer not granted last time wins.
          grant_d = (req0 && req1) ? ~grant_q : req1;
          state_d = StStart;
        end
      end
      StStart: begin
        // done is deliberately not looked at until STREAM.
        if (wdog_expired) begin
          state_d = StRelease;
        end else if (sel_start_ack) begin
          state_d = StStream;
        end
      end
      StStream: begin
        if (wdog_expired) begin
          state_d = StRelease;
        end else if (sel_done) begin
          state_d = StAck;
        end
      end
      StAck: begin
        state_d = StRelease;
      end
      StRelease: begin
        // Wait for start_ack to fall so the writer's start edge detector re-arms.
        if (!sel_start_ack) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output logic.
  always_comb begin
    start0     = 1'b0;
    start1     = 1'b0;
    done_ack0  = 1'b0;
    done_ack1  = 1'b0;
    din_ready0 = 1'b0;
    din_ready1 = 1'b0;
    dout       = 54'd0;
    dout_valid = 1'b0;
    busy       = (state_q != StIdle);
    case (state_q)
      StStart: begin
        start0 = ~grant_q;
        start1 = grant_q;
      end
      StStream: begin
        // Pure wire-through: no buffering, so no beat can be added or lost.
        if (grant_q) begin
          dout       = din1;
          dout_valid = din_valid1;
          din_ready1 = dout_ready;
        end else begin
          dout       = din0;
          dout_valid = din_valid0;
          din_ready0 = dout_ready;
        end
      end
      StAck: begin
        done_ack0 = ~grant_q;
        done_ack1 = grant_q;
      end
      default: begin
      end
    endcase
  end

  assign grant       = grant_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_frame_write_arbiter.sv
// Self-checking bench for frame_write_arbiter.
// A cycle-level behavioural model tracks the frame phase per writer and predicts
// every output; a negedge compare process checks the DUT against it, while the
// directed tests add hand-computed literal checks.

module tb_frame_write_arbiter;

  localparam int unsigned TimeoutCycles = 16;

  localparam int PIdle    = 0;
  localparam int PStart   = 1;
  localparam int PStream  = 2;
  localparam int PAck     = 3;
  localparam int PRelease = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [1:0]  start_ack = 2'b00;
  logic [1:0]  done = 2'b00;
  logic [1:0]  din_valid = 2'b00;
  logic [53:0] din [2];
  logic        dout_ready = 1'b1;

  logic        start0, start1, done_ack0, done_ack1, din_ready0, din_ready1;
  logic [53:0] dout;
  logic        dout_valid, busy, grant, timeout_err;
  logic [15:0] frame_count;

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  frame_write_arbiter #(
    .TIMEOUT_CYCLES(TimeoutCycles)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req0       (req[0]),
    .req1       (req[1]),
    .start0     (start0),
    .start1     (start1),
    .start_ack0 (start_ack[0]),
    .start_ack1 (start_ack[1]),
    .done0      (done[0]),
    .done1      (done[1]),
    .done_ack0  (done_ack0),
    .done_ack1  (done_ack1),
    .din0       (din[0]),
    .din1       (din[1]),
    .din_valid0 (din_valid[0]),
    .din_valid1 (din_valid[1]),
    .din_ready0 (din_ready0),
    .din_ready1 (din_ready1),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
    .grant      (grant),
    .frame_count(frame_count),
    .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  // ---------------- behavioural model ----------------
  int m_phase = PIdle;
  bit m_grant = 1'b1;
  int m_count = 0;
  int m_beats = 0;
  int m_wd = 0;
  bit m_toerr = 1'b0;

  always @(posedge clock) begin
    int ph;
    bit g;
    int cnt;
    int beats;
    int wd;
    bit aborted;
    ph = m_phase;
    g = m_grant;
    cnt = m_count;
    beats = m_beats;
    wd = m_wd;
    aborted = 1'b0;
    if (reset) begin
      ph = PIdle;
      g = 1'b1;
      cnt = 0;
      wd = 0;
    end else begin
`ifdef FRAME_ARB_TIMEOUT_EN
      if (ph == PStart || ph == PStream) begin
        if (wd == int'(TimeoutCycles) - 1) aborted = 1'b1;
        else wd = wd + 1;
      end
`endif
      case (ph)
        PIdle: if (req != 2'b00) begin
          g = (req == 2'b11) ? !g : req[1];
          ph = PStart;
          wd = 0;
          beats = 0;
        end
        PStart: if (aborted) ph = PRelease;
                else if (start_ack[g]) ph = PStream;
        PStream: begin
          if (din_valid[g] && dout_ready) beats = beats + 1;
          if (aborted) ph = PRelease;
          else if (done[g]) ph = PAck;
        end
        PAck: begin
          cnt = (cnt + 1) % 65536;
          ph = PRelease;
        end
        default: if (!start_ack[g]) ph = PIdle;
      endcase
    end
    m_phase <= ph;
    m_grant <= g;
    m_count <= cnt;
    m_beats <= beats;
    m_wd <= wd;
    m_toerr <= aborted;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    bit g;
    bit strm;
    if (chk_en) begin
      g = m_grant;
      strm = (m_phase == PStream);
      check("start0", start0, (m_phase == PStart) && !g);
      check("start1", start1, (m_phase == PStart) && g);
      check("done_ack0", done_ack0, (m_phase == PAck) && !g);
      check("done_ack1", done_ack1, (m_phase == PAck) && g);
      check("dout", dout, strm ? din[g] : 54'd0);
      check("dout_valid", dout_valid, strm && din_valid[g]);
      check("din_ready0", din_ready0, strm && !g && dout_ready);
      check("din_ready1", din_ready1, strm && g && dout_ready);
      check("busy", busy, m_phase != PIdle);
      check("grant", grant, g);
      check("frame_count", frame_count, m_count);
      check("timeout_err", timeout_err, m_toerr);
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [53:0] pat(input int n, input int b);
    return {4'(b + 1), 1'(n), 17'(n * 1000 + b), 32'hA5A5_0000 + 32'(b * 16 + n)};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_start(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if ((n == 0) ? start0 : start1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL start_wait writer%0d: actual=no start required=start", n);
    end
  endtask

  // One writer frame: start handshake, beats (optional initial stall), done,
  // then hold start_ack for `hold` RELEASE cycles.
  task automatic do_frame(input int n, input int beats, input int stall, input int hold,
                          input bit keep_req, input int exp_grant);
    bit ok;
    bit got;
    int h;
    wait_start(n, ok);
    if (!ok) return;
    check("grant_seq", grant, 64'(exp_grant));
    tick();
    check("start_hold", (n == 0) ? start0 : start1, 1);
    start_ack[n] = 1'b1;
    if (!keep_req) req[n] = 1'b0;
    tick();
    for (int b = 0; b < beats; b++) begin
      din[n] = pat(n, b);
      din_valid[n] = 1'b1;
      if (b == 0 && stall > 0) begin
        dout_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
          tick();
          check("stall_ready", {din_ready1, din_ready0}, 2'b00);
          check("stall_dout", dout, pat(n, 0));
        end
        dout_ready = 1'b1;
      end
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        #1;
        got = (n == 0) ? din_ready0 : din_ready1;
        tick();
      end
      if (!got) begin
        n_cmp++;
        n_fail++;
        $display("FAIL beat_wait writer%0d: actual=no ready required=ready", n);
      end
    end
    din_valid[n] = 1'b0;
    done[n] = 1'b1;
    tick();
    done[n] = 1'b0;
    check("done_ack_pulse", (n == 0) ? done_ack0 : done_ack1, 1);
    check("model_beats", m_beats, 64'(beats));
    tick();
    h = (hold == 0) ? 1 : hold;
    for (int i = 0; i < h; i++) begin
      check("release_busy", busy, 1);
      if (i == h - 1) start_ack[n] = 1'b0;
      tick();
    end
    if (!keep_req) check("idle_after_release", busy, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = 2'b00;
    start_ack = 2'b00;
    done = 2'b00;
    din_valid = 2'b00;
    dout_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    bit ok;
    din[0] = 54'd0;
    din[1] = 54'd0;
    tick();
    chk_en = 1'b1;
    do_reset();

    // Reset state.
    check("rst_busy", busy, 0);
    check("rst_grant", grant, 1);
    check("rst_frame_count", frame_count, 0);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_start", {start1, start0}, 2'b00);

    // Writer 0 alone: 4 beats, one frame.
    req[0] = 1'b1;
    do_frame(0, 4, 0, 0, 1'b0, 0);
    check("frame_count_1", frame_count, 1);

    // Writer 1: 5-cycle FIFO stall, start_ack held 3 cycles in RELEASE.
    req[1] = 1'b1;
    do_frame(1, 3, 5, 3, 1'b0, 1);
    check("frame_count_2", frame_count, 2);

    // Both requesting continuously: grants alternate 0,1,0,1.
    do_reset();
    req = 2'b11;
    do_frame(0, 2, 0, 0, 1'b1, 0);
    do_frame(1, 2, 0, 0, 1'b1, 1);
    do_frame(0, 1, 0, 0, 1'b1, 0);
    do_frame(1, 3, 0, 0, 1'b1, 1);
    req = 2'b00;
    check("frame_count_4", frame_count, 4);
    tick();
    check("idle_after_rr", busy, 0);

    // Reset in the middle of STREAM.
    do_reset();
    req[0] = 1'b1;
    wait_start(0, ok);
    start_ack[0] = 1'b1;
    req[0] = 1'b0;
    tick();
    din[0] = pat(0, 7);
    din_valid[0] = 1'b1;
    tick();
    check("mid_stream_valid", dout_valid, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_dout_valid", dout_valid, 0);
    check("rst_mid_frame_count", frame_count, 0);
    din_valid[0] = 1'b0;
    start_ack[0] = 1'b0;
    tick();

`ifdef FRAME_ARB_TIMEOUT_EN
    // Writer 1 never finishes; the watchdog pulses 16 cycles after START entry.
    do_reset();
    req[1] = 1'b1;
    wait_start(1, ok);
    start_ack[1] = 1'b1;
    req[1] = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      check("wdog_pulse", timeout_err, (c == 16) ? 1 : 0);
    end
    check("wdog_busy", busy, 1);
    check("wdog_no_done_ack", done_ack1, 0);
    check("wdog_frame_count", frame_count, 0);
    start_ack[1] = 1'b0;
    tick();
    check("wdog_idle", busy, 0);
`endif

    tick();
    tick();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
